as_decodestage_pipe: RTL
========================

Name: as_decodestage_pipe

Overview:
- Parametrised next-generation decode stage for the RV64I pipeline.
- Decodes one instruction per cycle and reads operands from an internal register file.
- Adds load-use hazard detection, flush handling and write-through bypass.
- Captures all decoded outputs in a registered ID/EX pipeline register with a valid bit, so the execute stage sees clean, registered inputs.

Parameters:
XLEN, 64, datapath and register width (32 or 64)
NREGS, 32, number of architectural registers (x0 hardwired to zero)
BYPASS, 1, 1 = a WB write to the same address is forwarded to a same-cycle read
HAZARD_EN, 1, 1 = load-use stall detection enabled; 0 = stall_o tied low

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
instr_i  in  32  instruction from the IF/ID register
pc_i  in  XLEN  PC of instr_i
valid_i  in  1  instr_i is a real instruction
flush_i  in  1  taken branch/jump resolved in EX; kill the instruction in decode
ex_rd_i  in  5  destination register of the instruction currently in EX
ex_load_i  in  1  instruction in EX is a load
wb_we_i  in  1  register-file write enable
wb_addr_i  in  5  register-file write address
wb_data_i  in  XLEN  register-file write data
stall_o  out  1  combinational; freeze PC and IF/ID
valid_o  out  1  ID/EX entry valid
pc_o  out  XLEN  registered PC
reg_a_o, reg_b_o  out  XLEN  registered rs1/rs2 operand values
imm_o  out  XLEN  registered sign-extended immediate
rs1_o, rs2_o, rd_o  out  5  registered register addresses, for forwarding
result_src_o  out  dmuxsel_width  registered result mux select
alu_sel_o  out  aluselrv_width  registered ALU operation
alu_src_a_o, alu_src_b_o, reg_wr_o, d_mem_wr_o, d_mem_rd_o, jump_o, branch_o  out  1 each  registered control bits

Behaviour:
- Latency: one cycle. Decode is combinational from instr_i; all outputs except stall_o update on the rising edge of clk_i.
- Reset (rst_i=0, asynchronous):
  - Every ID/EX output clears to 0, including valid_o.
  - All NREGS register-file entries clear to 0.
  - stall_o is 0 while reset is held.
- Register file:
  - Write on the rising edge when wb_we_i=1 and wb_addr_i!=0.
  - Reads of x0 always return 0.
  - Addresses >= NREGS are ignored on write and read as 0.
- Bypass (BYPASS=1): if wb_we_i=1, wb_addr_i!=0 and wb_addr_i equals rs1 (or rs2), the operand captured this cycle is wb_data_i. With BYPASS=0 the old value is captured.
- Register usage by opcode:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by R-type, S-type and B-type opcodes.
- Load-use hazard: stall_o = HAZARD_EN & valid_i & ex_load_i & (ex_rd_i!=0) & ((rs1 used & ex_rd_i==rs1) | (rs2 used & ex_rd_i==rs2)).
- Bubble:
  - Definition: valid_o=0 and every control bit, select, data and address output = 0.
  - A bubble is inserted when flush_i=1, when stall_o=1, or when valid_i=0.
  - flush_i has priority over stall_o; in the flush case stall_o is still reported, and the upstream stage ignores it on flush.
- Normal capture: otherwise valid_o=1 and all decoded fields are captured.
- Immediate generation and control decode use as_immgen and as_controlall unchanged. Their zero_i is tied to 0 and their PC-source output is left unconnected.
- Width rule: with XLEN=32, the immediate is truncated to 32 bits after sign extension, and word-op opcodes (OP-32, OP-IMM-32) decode as illegal, which is treated as a bubble.
- Reset asserted mid-stream clears any in-flight entry immediately; the first capture after release happens on the first rising edge with rst_i=1.

Decomposition:
- as_pack receives:
  - an id_ex_t packed struct holding all registered fields;
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_R, OPC_S, OPC_B, OPC_LOAD);
  - the existing dmuxsel_width and aluselrv_width.
- One sub-module: as_regfile_bypass, holding the parametrised register array, the x0 rule and the bypass mux.
- Hazard logic and the ID/EX register stay in the top module.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles, release -> valid_o=0, reg_a_o=0, and a read of x5 returns 0.
- ADDI x1,x0,5 (0x00500093) with valid_i=1 -> next edge: valid_o=1, imm_o=5, rd_o=1, reg_wr_o=1, alu_src_b_o=1.
- Bypass: wb_we_i=1, wb_addr_i=3, wb_data_i=0xDEAD, and in the same cycle ADD x4,x3,x0 -> reg_a_o=0xDEAD. With BYPASS=0 -> reg_a_o=old x3 value.
- Load-use: ex_load_i=1, ex_rd_i=2, and ADD x5,x2,x1 in decode -> stall_o=1 and the next edge gives valid_o=0 with all controls 0. With ex_rd_i=0 -> stall_o=0.
- Flush and stall together: flush_i=1 while stall_o=1 -> bubble captured; with flush_i=1 alone, an SD in decode yields d_mem_wr_o=0.
- x0 write: wb_we_i=1, wb_addr_i=0, wb_data_i=0xFF, then read x0 -> reg_a_o=0.

Source files
------------

// File: rtl/as_pack.sv
`default_nettype none
// ============================================================================
// as_pack : opcodes, select encodings, ID/EX record and decode helpers
// Rev 1.0
// ============================================================================
package as_pack;

    localparam int XLEN_MAX       = 64;
    localparam int dmuxsel_width  = 2;
    localparam int aluselrv_width = 4;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I32   = 7'b0011011;
    localparam logic [6:0] OPC_R32   = 7'b0111011;

    localparam logic [dmuxsel_width-1:0] RES_ALU = 2'd0;
    localparam logic [dmuxsel_width-1:0] RES_MEM = 2'd1;
    localparam logic [dmuxsel_width-1:0] RES_PC4 = 2'd2;
    localparam logic [dmuxsel_width-1:0] RES_IMM = 2'd3;

    localparam logic [aluselrv_width-1:0] ALU_ADD  = 4'd0;
    localparam logic [aluselrv_width-1:0] ALU_SUB  = 4'd1;
    localparam logic [aluselrv_width-1:0] ALU_SLL  = 4'd2;
    localparam logic [aluselrv_width-1:0] ALU_SLT  = 4'd3;
    localparam logic [aluselrv_width-1:0] ALU_SLTU = 4'd4;
    localparam logic [aluselrv_width-1:0] ALU_XOR  = 4'd5;
    localparam logic [aluselrv_width-1:0] ALU_SRL  = 4'd6;
    localparam logic [aluselrv_width-1:0] ALU_SRA  = 4'd7;
    localparam logic [aluselrv_width-1:0] ALU_OR   = 4'd8;
    localparam logic [aluselrv_width-1:0] ALU_AND  = 4'd9;
    localparam logic [aluselrv_width-1:0] ALU_ADDW = 4'd10;
    localparam logic [aluselrv_width-1:0] ALU_SUBW = 4'd11;
    localparam logic [aluselrv_width-1:0] ALU_SLLW = 4'd12;
    localparam logic [aluselrv_width-1:0] ALU_SRLW = 4'd13;
    localparam logic [aluselrv_width-1:0] ALU_SRAW = 4'd14;

    // Data fields are sized for the widest datapath; narrower builds zero-extend.
    typedef struct packed {
        logic                      valid;
        logic [XLEN_MAX-1:0]       pc;
        logic [XLEN_MAX-1:0]       reg_a;
        logic [XLEN_MAX-1:0]       reg_b;
        logic [XLEN_MAX-1:0]       imm;
        logic [4:0]                rs1;
        logic [4:0]                rs2;
        logic [4:0]                rd;
        logic [dmuxsel_width-1:0]  result_src;
        logic [aluselrv_width-1:0] alu_sel;
        logic                      alu_src_a;
        logic                      alu_src_b;
        logic                      reg_wr;
        logic                      d_mem_wr;
        logic                      d_mem_rd;
        logic                      jump;
        logic                      branch;
    } id_ex_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_R || opc == OPC_R32 || opc == OPC_S || opc == OPC_B);
    endfunction

    function automatic logic [aluselrv_width-1:0] alu_decode(input logic [2:0] f3,
                                                             input logic       alt,
                                                             input logic       word);
        logic [aluselrv_width-1:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        if (word) begin
            case (op)
                ALU_ADD: op = ALU_ADDW;
                ALU_SUB: op = ALU_SUBW;
                ALU_SLL: op = ALU_SLLW;
                ALU_SRL: op = ALU_SRLW;
                ALU_SRA: op = ALU_SRAW;
                default: op = op;
            endcase
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/as_controlall.sv
`default_nettype none
// ============================================================================
// as_controlall : main control decode; word ops are illegal on 32-bit builds
// Rev 1.0
// ============================================================================
module as_controlall
    import as_pack::*;
#(
    parameter int XLEN = 64
) (
    input  logic [6:0]                opcode_i,
    input  logic [2:0]                funct3_i,
    input  logic                      funct7b5_i,
    input  logic                      zero_i,
    output logic [dmuxsel_width-1:0]  result_src_o,
    output logic [aluselrv_width-1:0] alu_sel_o,
    output logic                      alu_src_a_o,
    output logic                      alu_src_b_o,
    output logic                      reg_wr_o,
    output logic                      d_mem_wr_o,
    output logic                      d_mem_rd_o,
    output logic                      jump_o,
    output logic                      branch_o,
    output logic                      pc_src_o,
    output logic                      illegal_o
);

    logic w_shift_alt;
    assign w_shift_alt = (funct3_i == 3'd5) && funct7b5_i;

    always_comb begin
        result_src_o = RES_ALU;
        alu_sel_o    = ALU_ADD;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 1'b0;
        reg_wr_o     = 1'b0;
        d_mem_wr_o   = 1'b0;
        d_mem_rd_o   = 1'b0;
        jump_o       = 1'b0;
        branch_o     = 1'b0;
        illegal_o    = 1'b0;
        case (opcode_i)
            OPC_LUI:   begin result_src_o = RES_IMM; alu_src_b_o = 1'b1; reg_wr_o = 1'b1; end
            OPC_AUIPC: begin alu_src_a_o = 1'b1; alu_src_b_o = 1'b1; reg_wr_o = 1'b1; end
            OPC_JAL:   begin jump_o = 1'b1; reg_wr_o = 1'b1; result_src_o = RES_PC4;
                             alu_src_a_o = 1'b1; alu_src_b_o = 1'b1; end
            OPC_JALR:  begin jump_o = 1'b1; reg_wr_o = 1'b1; result_src_o = RES_PC4;
                             alu_src_b_o = 1'b1; end
            OPC_B:     begin branch_o = 1'b1; alu_sel_o = ALU_SUB; end
            OPC_LOAD:  begin d_mem_rd_o = 1'b1; reg_wr_o = 1'b1; alu_src_b_o = 1'b1;
                             result_src_o = RES_MEM; end
            OPC_S:     begin d_mem_wr_o = 1'b1; alu_src_b_o = 1'b1; end
            OPC_I:     begin reg_wr_o = 1'b1; alu_src_b_o = 1'b1;
                             alu_sel_o = alu_decode(funct3_i, w_shift_alt, 1'b0); end
            OPC_R:     begin reg_wr_o = 1'b1;
                             alu_sel_o = alu_decode(funct3_i, funct7b5_i, 1'b0); end
            OPC_I32: begin
                if (XLEN == 64) begin
                    reg_wr_o    = 1'b1;
                    alu_src_b_o = 1'b1;
                    alu_sel_o   = alu_decode(funct3_i, w_shift_alt, 1'b1);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_R32: begin
                if (XLEN == 64) begin
                    reg_wr_o  = 1'b1;
                    alu_sel_o = alu_decode(funct3_i, funct7b5_i, 1'b1);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
        pc_src_o = jump_o | (branch_o & zero_i);
    end

endmodule
`default_nettype wire

// File: rtl/as_decodestage_pipe_regfile.sv
`default_nettype none
// ============================================================================
// as_regfile_bypass : NREGS x XLEN register file, x0 reads zero, optional WB bypass
// Rev 1.0
// ============================================================================
module as_regfile_bypass #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr_a_i,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            w_wr_hit;

    // Loops start at 1 so x0 and out-of-range addresses never match anything.
    always_comb begin
        regs_d   = regs_q;
        w_wr_hit = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (waddr_i == 5'(i)) begin
                w_wr_hit = 1'b1;
                if (we_i) regs_d[i] = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (addr == 5'(i)) val = regs_q[i];
        end
        if ((BYPASS != 0) && we_i && w_wr_hit && (waddr_i == addr)) val = wdata_i;
        return val;
    endfunction

    assign rdata_a_o = read_port(raddr_a_i);
    assign rdata_b_o = read_port(raddr_b_i);

endmodule
`default_nettype wire

// File: rtl/as_immgen.sv
`default_nettype none
// ============================================================================
// as_immgen : 64-bit sign-extended immediate for every RV64I format
// Rev 1.0
// ============================================================================
module as_immgen
    import as_pack::*;
(
    input  logic [31:0] instr_i,
    output logic [63:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (instr_i[6:0])
            OPC_I, OPC_I32, OPC_LOAD, OPC_JALR:
                imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
            OPC_S:
                imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_B:
                imm_o = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/as_decodestage_pipe.sv
`default_nettype none
// ============================================================================
// as_decodestage_pipe : RV64I decode with load-use stall, flush and ID/EX register
// Rev 1.0
// ============================================================================
module as_decodestage_pipe
    import as_pack::*;
#(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter int BYPASS    = 1,
    parameter int HAZARD_EN = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               instr_i,
    input  logic [XLEN-1:0]           pc_i,
    input  logic                      valid_i,
    input  logic                      flush_i,
    input  logic [4:0]                ex_rd_i,
    input  logic                      ex_load_i,
    input  logic                      wb_we_i,
    input  logic [4:0]                wb_addr_i,
    input  logic [XLEN-1:0]           wb_data_i,
    output logic                      stall_o,
    output logic                      valid_o,
    output logic [XLEN-1:0]           pc_o,
    output logic [XLEN-1:0]           reg_a_o,
    output logic [XLEN-1:0]           reg_b_o,
    output logic [XLEN-1:0]           imm_o,
    output logic [4:0]                rs1_o,
    output logic [4:0]                rs2_o,
    output logic [4:0]                rd_o,
    output logic [dmuxsel_width-1:0]  result_src_o,
    output logic [aluselrv_width-1:0] alu_sel_o,
    output logic                      alu_src_a_o,
    output logic                      alu_src_b_o,
    output logic                      reg_wr_o,
    output logic                      d_mem_wr_o,
    output logic                      d_mem_rd_o,
    output logic                      jump_o,
    output logic                      branch_o
);

    logic [6:0]                opcode;
    logic [4:0]                rs1, rs2, rd;
    logic [XLEN-1:0]           rdata_a, rdata_b;
    logic [63:0]               imm_full;
    logic [dmuxsel_width-1:0]  ctl_result_src;
    logic [aluselrv_width-1:0] ctl_alu_sel;
    logic                      ctl_src_a, ctl_src_b, ctl_reg_wr, ctl_mem_wr, ctl_mem_rd;
    logic                      ctl_jump, ctl_branch, ctl_illegal;
    logic                      pc_src_unused;
    id_ex_t                    id_ex_d, id_ex_q;

    assign opcode = instr_i[6:0];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign rd     = instr_i[11:7];

    as_regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (wb_we_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b)
    );

    as_immgen u_immgen (
        .instr_i (instr_i),
        .imm_o   (imm_full)
    );

    as_controlall #(.XLEN(XLEN)) u_control (
        .opcode_i     (opcode),
        .funct3_i     (instr_i[14:12]),
        .funct7b5_i   (instr_i[30]),
        .zero_i       (1'b0),
        .result_src_o (ctl_result_src),
        .alu_sel_o    (ctl_alu_sel),
        .alu_src_a_o  (ctl_src_a),
        .alu_src_b_o  (ctl_src_b),
        .reg_wr_o     (ctl_reg_wr),
        .d_mem_wr_o   (ctl_mem_wr),
        .d_mem_rd_o   (ctl_mem_rd),
        .jump_o       (ctl_jump),
        .branch_o     (ctl_branch),
        .pc_src_o     (pc_src_unused),
        .illegal_o    (ctl_illegal)
    );

    // Held low during reset so the front end never freezes on stale inputs.
    assign stall_o = (HAZARD_EN != 0) && rst_i && valid_i && ex_load_i && (ex_rd_i != 5'd0) &&
                     ((uses_rs1(opcode) && (ex_rd_i == rs1)) ||
                      (uses_rs2(opcode) && (ex_rd_i == rs2)));

    always_comb begin
        id_ex_d = '0;
        if (valid_i && !flush_i && !stall_o && !ctl_illegal) begin
            id_ex_d.valid      = 1'b1;
            id_ex_d.pc         = XLEN_MAX'(pc_i);
            id_ex_d.reg_a      = XLEN_MAX'(rdata_a);
            id_ex_d.reg_b      = XLEN_MAX'(rdata_b);
            id_ex_d.imm        = XLEN_MAX'(imm_full[XLEN-1:0]);
            id_ex_d.rs1        = rs1;
            id_ex_d.rs2        = rs2;
            id_ex_d.rd         = rd;
            id_ex_d.result_src = ctl_result_src;
            id_ex_d.alu_sel    = ctl_alu_sel;
            id_ex_d.alu_src_a  = ctl_src_a;
            id_ex_d.alu_src_b  = ctl_src_b;
            id_ex_d.reg_wr     = ctl_reg_wr;
            id_ex_d.d_mem_wr   = ctl_mem_wr;
            id_ex_d.d_mem_rd   = ctl_mem_rd;
            id_ex_d.jump       = ctl_jump;
            id_ex_d.branch     = ctl_branch;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) id_ex_q <= '0;
        else        id_ex_q <= id_ex_d;
    end

    assign valid_o      = id_ex_q.valid;
    assign pc_o         = id_ex_q.pc[XLEN-1:0];
    assign reg_a_o      = id_ex_q.reg_a[XLEN-1:0];
    assign reg_b_o      = id_ex_q.reg_b[XLEN-1:0];
    assign imm_o        = id_ex_q.imm[XLEN-1:0];
    assign rs1_o        = id_ex_q.rs1;
    assign rs2_o        = id_ex_q.rs2;
    assign rd_o         = id_ex_q.rd;
    assign result_src_o = id_ex_q.result_src;
    assign alu_sel_o    = id_ex_q.alu_sel;
    assign alu_src_a_o  = id_ex_q.alu_src_a;
    assign alu_src_b_o  = id_ex_q.alu_src_b;
    assign reg_wr_o     = id_ex_q.reg_wr;
    assign d_mem_wr_o   = id_ex_q.d_mem_wr;
    assign d_mem_rd_o   = id_ex_q.d_mem_rd;
    assign jump_o       = id_ex_q.jump;
    assign branch_o     = id_ex_q.branch;

endmodule
`default_nettype wire
